// File: rtl/parity_frame_rx.sv
// ---------------------------------------------------------------------------
// parity_frame_rx
//
// Receives one serial frame per bit_en-paced bit stream. A frame is a start
// bit (0), DATA_W data bits sent LSB first, a parity bit and a stop bit (1).
// rx_in is sampled only in cycles where bit_en is high, so the block can be
// paced by any baud-rate strobe, including one that is tied high.
//
// When the stop bit is sampled:
//   - the received word is published on data_out,
//   - parity_err reports a parity mismatch for the configured parity mode,
//   - frame_err reports a stop bit sampled as 0,
//   - data_valid pulses high for exactly one clock cycle.
// These results hold until the next completed frame.
//
// Parameters
//   DATA_W     data bits per frame (2..16)
//   ODD        parity mode: 0 = even parity, 1 = odd parity
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   bit_en     bit strobe; rx_in is sampled only when this is 1
//   rx_in      serial input line, idle high
//   data_out   last received data word
//   data_valid one-cycle pulse marking a completed frame
//   parity_err parity check result of the last frame (1 = mismatch)
//   frame_err  stop-bit check result of the last frame (1 = stop bit was 0)
//   busy       high while a frame is in progress (state is not IDLE)
// ---------------------------------------------------------------------------
module parity_frame_rx #(
    parameter int DATA_W = 8,
    parameter int ODD    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    // Counter only has to index data bits 0..DATA_W-1.
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic ODD_BIT = (ODD != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t            state_q,      state_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic [DATA_W-1:0] shift_q,      shift_d;
    logic              par_bit_q,    par_bit_d;
    logic [DATA_W-1:0] data_out_q,   data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q,  frame_err_d;
    logic              busy_q,       busy_d;

    // Next-state and next-output computation. Everything holds by default;
    // data_valid defaults low so it can never be stretched by idle cycles.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        if (bit_en) begin
            unique case (state_q)
                IDLE: begin
                    // A 0 on an idle strobe is a start bit.
                    if (!rx_in) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        shift_d = '0;
                    end
                end

                DATA: begin
                    // Data arrives LSB first, so the bit index is the count.
                    shift_d[cnt_q] = rx_in;
                    if (cnt_q == LAST_BIT) begin
                        state_d = PARITY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                PARITY: begin
                    par_bit_d = rx_in;
                    state_d   = STOP;
                end

                STOP: begin
                    // A 0 here is a framing error, never a new start bit;
                    // the next start is only looked for from IDLE.
                    state_d      = IDLE;
                    data_out_d   = shift_q;
                    data_valid_d = 1'b1;
                    frame_err_d  = ~rx_in;
                    // Data XOR parity bit must equal the mode bit: 0 for even
                    // parity, 1 for odd parity.
                    parity_err_d = ((^shift_q) ^ par_bit_q) != ODD_BIT;
                end

                default: state_d = IDLE;
            endcase
        end

        // busy is registered from the next state so it tracks state_q exactly.
        busy_d = (state_d != IDLE);
    end

    // Single state register for the FSM, datapath and all outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule

// File: doc/parity_frame_rx.md
PARITY_FRAME_RX -- requirements
Module: parity_frame_rx

Interface
REQ-001 Parameter DATA_W, default 8, number of data bits per frame (legal 2..16).
REQ-002 Parameter ODD, default 0, parity mode: 0 = even parity, 1 = odd parity.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 bit_en  input  1  bit strobe; rx_in is sampled only in cycles where bit_en=1.
REQ-006 rx_in  input  1  serial line, idle high.
REQ-007 data_out  output  DATA_W  last received data word.
REQ-008 data_valid  output  1  one-cycle pulse marking a completed frame.
REQ-009 parity_err  output  1  parity check result of last frame; 1 = mismatch.
REQ-010 frame_err  output  1  stop-bit check result of last frame; 1 = stop bit sampled 0.
REQ-011 busy  output  1  high while a frame is in progress, i.e. state is not IDLE.

Function
REQ-012 The frame format SHALL be: start bit (0), DATA_W data bits LSB first, parity bit, stop bit (1), with one bit per bit_en strobe.
REQ-013 The FSM SHALL have the states IDLE, DATA, PARITY and STOP.
REQ-014 In IDLE, bit_en=1 with rx_in=0 SHALL move the FSM to DATA with the bit counter cleared; bit_en=1 with rx_in=1 SHALL keep it in IDLE.
REQ-015 In DATA, each bit_en SHALL shift rx_in into bit position (count) of the shift register and increment the count; the DATA_W-th strobe SHALL move the FSM to PARITY.
REQ-016 In PARITY, bit_en SHALL capture rx_in as the received parity bit and move the FSM to STOP.
REQ-017 In STOP, bit_en SHALL sample the stop bit and return the FSM to IDLE on the same edge.
REQ-018 On the STOP-sampling edge, data_out, parity_err and frame_err SHALL update and data_valid SHALL go high for exactly one cycle (latency 1 clock after the stop strobe).
REQ-019 parity_err SHALL be 1 when (XOR of the DATA_W data bits) XOR (parity bit) differs from ODD, and 0 otherwise.
REQ-020 frame_err SHALL be 1 when the stop bit is sampled as 0; data_valid SHALL still pulse, and data_out SHALL still be updated.
REQ-021 data_out, parity_err and frame_err SHALL hold their values between data_valid pulses.
REQ-022 Cycles with bit_en=0 SHALL leave all state unchanged and SHALL NOT stretch data_valid.
REQ-023 A start bit SHALL NOT be accepted in the STOP state; a 0 on the STOP strobe is a frame error, and the next start is detected from IDLE.
REQ-024 bit_en held high continuously SHALL be legal and SHALL give back-to-back frames with no lost bits.
REQ-025 busy SHALL be 1 in DATA, PARITY and STOP, and 0 in IDLE.

Reset
REQ-026 When rst_n=0, the FSM SHALL go to IDLE and the bit counter, shift register, data_out, data_valid, parity_err, frame_err and busy SHALL all go to 0 asynchronously.
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no data_valid pulse; after release, the block SHALL wait for a new start bit.
REQ-028 The first rising edge after rst_n goes high SHALL operate normally.

Verification
REQ-029 ODD=0, byte 0xA5 (parity 0), stop 1 -> data_out=0xA5, data_valid one cycle, parity_err=0, frame_err=0.
REQ-030 ODD=0, byte 0x07 with parity bit 0 -> data_out=0x07, parity_err=1; ODD=1 with the same frame -> parity_err=0.
REQ-031 Byte 0x3C with correct parity and stop bit 0 -> data_valid pulses, data_out=0x3C, frame_err=1, parity_err=0.
REQ-032 Frame 0x55 sent with bit_en every 4th cycle -> identical result to continuous bit_en; data_valid is exactly 1 cycle wide.
REQ-033 rst_n pulsed low after the 4th data bit, then a full frame 0x81 -> only one data_valid, with data_out=0x81; busy=0 during reset.
REQ-034 Two back-to-back frames 0xFF then 0x00 with bit_en tied high -> two data_valid pulses, 11 cycles apart, with the correct data each.
